// File: rtl/sm_hex_scan.sv
// sm_hex_scan: snapshots a CPU debug register and scans it as 8 hex digits on a common-anode display
module sm_hex_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  dispReg,
    input  logic        hold,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [6:0]  seg,
    output logic [7:0]  anode
);
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [31:0] r_snap;
    logic        r_pend;
    logic        w_tick, w_fend, w_match, w_load, w_blank;
    logic [3:0]  w_nib;
    logic [6:0]  w_font;
    assign w_tick  = r_cnt == 16'(REFRESH_DIV - 1);
    assign w_fend  = w_tick && r_idx == 3'd7;
    assign w_match = dispReg == regAddr;
    assign w_load  = !hold && ((r_pend && w_match) || w_fend);
    assign w_nib   = r_snap[{r_idx, 2'b00} +: 4];
    assign w_blank = BLANK_LZ && r_idx != 3'd0 && (r_snap >> {r_idx, 2'b00}) == 32'd0;
    always_comb begin
        w_font = 7'h7F;
        case (w_nib)
            4'h0: w_font = 7'h40;
            4'h1: w_font = 7'h79;
            4'h2: w_font = 7'h24;
            4'h3: w_font = 7'h30;
            4'h4: w_font = 7'h19;
            4'h5: w_font = 7'h12;
            4'h6: w_font = 7'h02;
            4'h7: w_font = 7'h78;
            4'h8: w_font = 7'h00;
            4'h9: w_font = 7'h10;
            4'hA: w_font = 7'h08;
            4'hB: w_font = 7'h03;
            4'hC: w_font = 7'h46;
            4'hD: w_font = 7'h21;
            4'hE: w_font = 7'h06;
            4'hF: w_font = 7'h0E;
        endcase
    end
    // pending re-arms whenever the select moves, so a load waits for regData of the new address
    always_ff @(posedge clk) begin
        if (rst) begin
            regAddr <= 5'd0;
            r_cnt   <= 16'd0;
            r_idx   <= 3'd0;
            r_snap  <= 32'd0;
            r_pend  <= 1'b1;
            seg     <= 7'h7F;
            anode   <= 8'hFF;
        end else begin
            regAddr <= dispReg;
            r_cnt   <= w_tick ? 16'd0 : r_cnt + 16'd1;
            r_idx   <= r_idx + 3'(w_tick);
            r_snap  <= w_load ? regData : r_snap;
            r_pend  <= !w_match || (r_pend && !w_load);
            seg     <= w_blank ? 7'h7F : w_font;
            anode   <= w_blank ? 8'hFF : ~(8'b1 << r_idx);
        end
    end
endmodule
